// File: rtl/mitchel_pkg.sv
// mitchel_pkg: shared defaults for the Mitchell logarithmic multiplier.
//   MITCHEL_N  - default operand width
//   MITCHEL_PW - default product width
//   MITCHEL_LW - width of a leading-one position for the default operand width
package mitchel_pkg;
  localparam int unsigned MITCHEL_N  = 9;
  localparam int unsigned MITCHEL_PW = 17;
  localparam int unsigned MITCHEL_LW = $clog2(MITCHEL_N);
endpackage

// File: rtl/mitchel_mul_if.sv
// mitchel_mul_if: operand/result bundle for mitchel_mul.
//   in_valid, x, y : request side (driven by master)
//   out_valid, p   : result side  (driven by slave)
interface mitchel_mul_if
  import mitchel_pkg::*;
#(
  parameter int unsigned N  = MITCHEL_N,
  parameter int unsigned PW = MITCHEL_PW
);
  logic          in_valid;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          out_valid;
  logic [PW-1:0] p;

  modport master (output in_valid, output x, output y, input  out_valid, input  p);
  modport slave  (input  in_valid, input  x, input  y, output out_valid, output p);
endinterface

// File: rtl/mitchel_lod.sv
// mitchel_lod: leading-one detector.
//   i_v    : N-bit value
//   o_pos  : bit index of the most significant one (0 when i_v is zero)
//   o_zero : high when i_v is zero
module mitchel_lod
  import mitchel_pkg::*;
#(
  parameter int unsigned N  = MITCHEL_N,
  parameter int unsigned LW = $clog2(N)
) (
  input  logic [N-1:0]  i_v,
  output logic [LW-1:0] o_pos,
  output logic          o_zero
);
  // Ascending scan: the last set bit seen wins, giving the MSB position.
  always_comb begin
    o_pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_v[i]) o_pos = LW'(i);
    end
  end

  assign o_zero = ~|i_v;
endmodule

// File: rtl/mitchel_mul.sv
// mitchel_mul: Mitchell logarithmic approximate multiplier, unsigned,
// saturating to PW bits, one result per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mitchel_mul_if.slave (in_valid/x/y in, out_valid/p out)
// Optional build macro MITCHEL_IN_REG_EN adds an input register stage
// (latency 2 instead of 1).
module mitchel_mul
  import mitchel_pkg::*;
#(
  parameter int unsigned N  = MITCHEL_N,
  parameter int unsigned PW = MITCHEL_PW
) (
  input  logic          clk,
  input  logic          rst,
  mitchel_mul_if.slave  bus
);
  localparam int unsigned LW = $clog2(N);
  localparam logic [LW-1:0] KMAX = LW'(N - 1);

  logic          w_v;
  logic [N-1:0]  w_x;
  logic [N-1:0]  w_y;

`ifdef MITCHEL_IN_REG_EN
  logic          r_v;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 1'b0;
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_v <= bus.in_valid;
      r_x <= bus.x;
      r_y <= bus.y;
    end
  end

  assign w_v = r_v;
  assign w_x = r_x;
  assign w_y = r_y;
`else
  assign w_v = bus.in_valid;
  assign w_x = bus.x;
  assign w_y = bus.y;
`endif

  logic [LW-1:0] w_k1, w_k2;
  logic          w_z1, w_z2;

  mitchel_lod #(.N(N), .LW(LW)) u_lod_x (.i_v(w_x), .o_pos(w_k1), .o_zero(w_z1));
  mitchel_lod #(.N(N), .LW(LW)) u_lod_y (.i_v(w_y), .o_pos(w_k2), .o_zero(w_z2));

  logic [N-2:0]    w_f1, w_f2;
  logic [N-1:0]    w_s;
  logic [N-1:0]    w_m;
  logic [LW:0]     w_e;
  logic [3*N-2:0]  w_wide;
  logic [2*N-1:0]  w_res;
  logic            w_ovf;
  logic [PW-1:0]   w_p;

  // Both carry cases collapse to one antilog: with c=1 the sum S already has
  // its top bit set, so mantissa {1,S[N-2:0]} equals S and only the exponent
  // gains c. Result = (mantissa << (k1+k2+c)) >> (N-1), floor by truncation.
  always_comb begin
    w_f1   = (N-1)'(w_x << (KMAX - w_k1));
    w_f2   = (N-1)'(w_y << (KMAX - w_k2));
    w_s    = {1'b0, w_f1} + {1'b0, w_f2};
    w_m    = {1'b1, w_s[N-2:0]};
    w_e    = {1'b0, w_k1} + {1'b0, w_k2} + {{LW{1'b0}}, w_s[N-1]};
    w_wide = {{(2*N-1){1'b0}}, w_m} << w_e;
    w_res  = (2*N)'(w_wide >> (N-1));
    w_ovf  = 1'b0;
    for (int unsigned i = PW; i < 2*N; i++) begin
      w_ovf = w_ovf | w_res[i];
    end
    if (w_z1 || w_z2) begin
      w_p = '0;
    end else if (w_ovf) begin
      w_p = '1;
    end else begin
      w_p = w_res[PW-1:0];
    end
  end

  logic          r_ov;
  logic [PW-1:0] r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov <= 1'b0;
      r_p  <= '0;
    end else begin
      r_ov <= w_v;
      if (w_v) r_p <= w_p;
    end
  end

  assign bus.out_valid = r_ov;
  assign bus.p         = r_p;
endmodule

// File: tb/tb_mitchel_mul.sv
// tb_mitchel_mul: directed checks of mitchel_mul (reset, Mitchell products on
// both carry paths, zero operands, exact powers of two, saturation boundary,
// streaming/hold behaviour, asynchronous reset, error bounds).
module tb_mitchel_mul;
  import mitchel_pkg::*;

  localparam int unsigned N  = MITCHEL_N;
  localparam int unsigned PW = MITCHEL_PW;
`ifdef MITCHEL_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mitchel_mul_if #(.N(N), .PW(PW)) bus ();

  mitchel_mul #(.N(N), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated transaction: present operands for one cycle, then wait out
  // the latency and compare at the falling edge.
  task automatic single(input string tag, input int xv, input int yv, input int exp);
    bus.x        = N'(xv);
    bus.y        = N'(yv);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check({tag, ".p"}, 32'(bus.p), 32'(exp));
    check({tag, ".ov"}, 32'(bus.out_valid), 32'd1);
  endtask

  int sx[3] = '{5, 3, 16};
  int sy[3] = '{6, 3, 32};
  int sp[3] = '{28, 8, 512};

  initial begin
    int last_p;
    int xv, yv, pv, ex;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;

    #3;
    check("reset.p", 32'(bus.p), 32'd0);
    check("reset.ov", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    single("zero_x",    0,   200, 0);
    single("zero_y",    200, 0,   0);
    single("pow2",      16,  32,  512);
    single("c0_5x6",    5,   6,   28);
    single("c1_3x3",    3,   3,   8);
    single("c0_7x9",    7,   9,   60);
    single("max8",      255, 255, 65024);
    single("one_x511",  1,   511, 511);
    single("pow2_256",  256, 256, 65536);
    single("edge_511x256", 511, 256, 130816);
    single("sat_511x257",  511, 257, 131071);
    single("sat_511x511",  511, 511, 131071);
    last_p = 131071;

    // After the last single transaction out_valid must have dropped and p held.
    @(negedge clk);
    check("idle.ov", 32'(bus.out_valid), 32'd0);
    check("idle.p", 32'(bus.p), 32'd131071);

    // Back-to-back stream of three, then three idle cycles.
    for (int i = 0; i < 6 + LAT - 1; i++) begin
      int j;
      if (i < 3) begin
        bus.x = N'(sx[i]);
        bus.y = N'(sy[i]);
        bus.in_valid = 1'b1;
      end else begin
        bus.x = N'(9'd77);
        bus.y = N'(9'd99);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      j = i - (LAT - 1);
      if (j >= 0 && j < 3) last_p = sp[j];
      check($sformatf("stream%0d.ov", i), 32'(bus.out_valid), (j >= 0 && j < 3) ? 32'd1 : 32'd0);
      check($sformatf("stream%0d.p", i), 32'(bus.p), 32'(last_p));
    end

    // Powers of two on one side give exact products.
    for (int k = 0; k < 8; k++) begin
      yv = int'($urandom_range(255, 1));
      single($sformatf("exact_2^%0d", k), 1 << k, yv, (1 << k) * yv);
    end

    // Random pairs: never above exact, never more than ~11.2% below.
    for (int i = 0; i < 200; i++) begin
      xv = int'($urandom_range(255, 1));
      yv = int'($urandom_range(255, 1));
      bus.x = N'(xv);
      bus.y = N'(yv);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      pv = int'(bus.p);
      ex = xv * yv;
      check($sformatf("bound_hi %0dx%0d p=%0d", xv, yv, pv), 32'(pv <= ex), 32'd1);
      check($sformatf("bound_lo %0dx%0d p=%0d", xv, yv, pv), 32'(pv * 1000 >= ex * 888), 32'd1);
    end

    // Asynchronous reset while a result is being presented.
    bus.x = N'(9'd16);
    bus.y = N'(9'd32);
    bus.in_valid = 1'b1;
    repeat (LAT) @(posedge clk);
    #2;
    check("prerst.ov", 32'(bus.out_valid), 32'd1);
    check("prerst.p", 32'(bus.p), 32'd512);
    rst = 1'b1;
    #1;
    check("asyncrst.p", 32'(bus.p), 32'd0);
    check("asyncrst.ov", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("inrst.ov", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;

    // First edge after reset release accepts a new operand pair.
    single("postrst", 5, 6, 28);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
